// File: rtl/ddr2_tb_pkg.sv
// Shared constants for the DDR2 address-FIFO reader: command codes,
// address field positions, stored-entry layout and FSM state encoding.
package ddr2_tb_pkg;

  localparam logic [3:0] RAW_REFRESH   = 4'h1;
  localparam logic [3:0] RAW_PRECHARGE = 4'h2;
  localparam logic [3:0] RAW_WRITE     = 4'h4;
  localparam logic [3:0] RAW_READ      = 4'h5;

  localparam logic [2:0] CMD_REFRESH   = 3'd1;
  localparam logic [2:0] CMD_PRECHARGE = 3'd2;
  localparam logic [2:0] CMD_WRITE     = 3'd4;
  localparam logic [2:0] CMD_READ      = 3'd5;

  localparam int unsigned CODE_HI = 35;
  localparam int unsigned CODE_LO = 32;
  localparam int unsigned BANK_HI = 25;
  localparam int unsigned BANK_LO = 24;
  localparam int unsigned ROW_HI  = 23;
  localparam int unsigned ROW_LO  = 10;
  localparam int unsigned COL_HI  = 9;
  localparam int unsigned COL_LO  = 0;

  // Stored entry keeps only the code and address[25:0]; lower bits keep their positions.
  localparam int unsigned ENTRY_W = 30;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic       legal;
    logic [2:0] code;
  } dec_t;

  function automatic dec_t decode_code(input logic [3:0] raw);
    dec_t d;
    d = '0;
    case (raw)
      RAW_REFRESH:   d = '{legal: 1'b1, code: CMD_REFRESH};
      RAW_PRECHARGE: d = '{legal: 1'b1, code: CMD_PRECHARGE};
      RAW_WRITE:     d = '{legal: 1'b1, code: CMD_WRITE};
      RAW_READ:      d = '{legal: 1'b1, code: CMD_READ};
      default:       d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ddr2_af_sync_fifo.sv
// Synchronous FIFO with registered read port. rd_en loads rd_data with the
// head as it stands after this edge's pop, so pop+read fetches the next entry.
module ddr2_af_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 30
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             do_wr, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = rd_data_q;

  always_comb begin
    do_pop    = pop && !empty;
    // A push into a full FIFO still lands when the same edge frees a slot.
    do_wr     = wr_en && (!full || do_pop);
    wr_ptr_d  = do_wr  ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_pop};
    rd_data_d = rd_en ? mem[rd_ptr_d] : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: rtl/ddr2_af_reader_0.sv
// Address-FIFO reader: buffers app_af pushes, decodes each entry and presents
// it on a valid/ready command port, with sticky error flags and command counters.
module ddr2_af_reader_0
  import ddr2_tb_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_LVL = 12
) (
  input  logic        clk0,
  input  logic        rst_n,
  input  logic [35:0] app_af_addr,
  input  logic        app_af_wren,
  output logic        app_af_afull,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_code,
  output logic [1:0]  cmd_bank,
  output logic [13:0] cmd_row,
  output logic [9:0]  cmd_col,
  output logic        err_illegal,
  output logic        err_overflow,
  output logic [15:0] wr_cmd_cnt,
  output logic [15:0] rd_cmd_cnt
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic               fifo_rd_en, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_wr_data, fifo_rd_data;
  logic [CW-1:0]      fifo_count;
  logic               unused_addr_bits;
  dec_t               dec;

  state_e      state_q, state_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [2:0]  cmd_code_q, cmd_code_d;
  logic [1:0]  cmd_bank_q, cmd_bank_d;
  logic [13:0] cmd_row_q, cmd_row_d;
  logic [9:0]  cmd_col_q, cmd_col_d;
  logic        err_ill_q, err_ill_d;
  logic        err_ovf_q, err_ovf_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;

  assign fifo_wr_data     = {app_af_addr[CODE_HI:CODE_LO], app_af_addr[BANK_HI:COL_LO]};
  assign unused_addr_bits = ^app_af_addr[CODE_LO-1:BANK_HI+1];

  ddr2_af_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk0),
    .rst_n   (rst_n),
    .wr_en   (app_af_wren),
    .wr_data (fifo_wr_data),
    .rd_en   (fifo_rd_en),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign app_af_afull = (fifo_count >= CW'(AFULL_LVL));
  assign cmd_valid    = cmd_valid_q;
  assign cmd_code     = cmd_code_q;
  assign cmd_bank     = cmd_bank_q;
  assign cmd_row      = cmd_row_q;
  assign cmd_col      = cmd_col_q;
  assign err_illegal  = err_ill_q;
  assign err_overflow = err_ovf_q;
  assign wr_cmd_cnt   = wr_cnt_q;
  assign rd_cmd_cnt   = rd_cnt_q;

  // The presented entry stays in the FIFO until accepted, so occupancy counts it.
  always_comb begin
    dec         = decode_code(fifo_rd_data[ENTRY_W-1 -: 4]);
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_code_d  = cmd_code_q;
    cmd_bank_d  = cmd_bank_q;
    cmd_row_d   = cmd_row_q;
    cmd_col_d   = cmd_col_q;
    err_ill_d   = err_ill_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    fifo_rd_en  = 1'b0;
    fifo_pop    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = ST_POP;
        end
      end
      ST_POP: begin
        cmd_code_d = dec.code;
        cmd_bank_d = fifo_rd_data[BANK_HI:BANK_LO];
        cmd_row_d  = fifo_rd_data[ROW_HI:ROW_LO];
        cmd_col_d  = fifo_rd_data[COL_HI:COL_LO];
        if (dec.legal) begin
          cmd_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          err_ill_d = 1'b1;
          fifo_pop  = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          fifo_pop    = 1'b1;
          if (cmd_code_q == CMD_WRITE) wr_cnt_d = wr_cnt_q + 16'd1;
          if (cmd_code_q == CMD_READ)  rd_cnt_d = rd_cnt_q + 16'd1;
          if (fifo_count > CW'(1)) begin
            fifo_rd_en = 1'b1;
            state_d    = ST_POP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    err_ovf_d = err_ovf_q | (app_af_wren & fifo_full & ~fifo_pop);
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= '0;
      cmd_bank_q  <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      err_ill_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      cmd_bank_q  <= cmd_bank_d;
      cmd_row_q   <= cmd_row_d;
      cmd_col_q   <= cmd_col_d;
      err_ill_q   <= err_ill_d;
      err_ovf_q   <= err_ovf_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
    end
  end

endmodule

// File: tb/tb_ddr2_af_reader_0.sv
// Directed bench for ddr2_af_reader_0: table of single-command vectors plus
// hand-written sequences for hold, illegal codes, overflow, reset and wrap.
module tb_ddr2_af_reader_0;

  logic        clk0 = 1'b0;
  logic        rst_n;
  logic [35:0] app_af_addr;
  logic        app_af_wren;
  logic        app_af_afull;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_code;
  logic [1:0]  cmd_bank;
  logic [13:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        err_illegal;
  logic        err_overflow;
  logic [15:0] wr_cmd_cnt;
  logic [15:0] rd_cmd_cnt;

  ddr2_af_reader_0 #(
    .DEPTH     (16),
    .AFULL_LVL (12)
  ) dut (
    .clk0         (clk0),
    .rst_n        (rst_n),
    .app_af_addr  (app_af_addr),
    .app_af_wren  (app_af_wren),
    .app_af_afull (app_af_afull),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_code     (cmd_code),
    .cmd_bank     (cmd_bank),
    .cmd_row      (cmd_row),
    .cmd_col      (cmd_col),
    .err_illegal  (err_illegal),
    .err_overflow (err_overflow),
    .wr_cmd_cnt   (wr_cmd_cnt),
    .rd_cmd_cnt   (rd_cmd_cnt)
  );

  always #5 clk0 = ~clk0;

  typedef struct {
    logic [35:0] addr;
    bit          ready_early;
    logic [2:0]  code;
    logic [1:0]  bank;
    logic [13:0] row;
    logic [9:0]  col;
  } vec_t;

  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;
  int   exp_wr = 0;
  int   exp_rd = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk0);
    @(negedge clk0);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (cmd_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk(name, cmd_valid, 1);
  endtask

  task automatic count_model(input logic [2:0] code);
    if (code == 3'd4) exp_wr = (exp_wr + 1) % 65536;
    if (code == 3'd5) exp_rd = (exp_rd + 1) % 65536;
  endtask

  task automatic push(input logic [35:0] a);
    app_af_addr = a;
    app_af_wren = 1'b1;
    step();
    app_af_wren = 1'b0;
  endtask

  task automatic do_write_cmd(input logic [31:0] a);
    push({4'h4, a});
    wait_valid("wr_valid");
    chk("wr_code", cmd_code, 3'd4);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    count_model(3'd4);
    chk("wr_cnt", wr_cmd_cnt, exp_wr[15:0]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nvalid;
    logic [2:0] seen_code;

    vecs[0] = '{36'h4_0003C0EC, 1'b1, 3'd4, 2'd0, 14'h00F0, 10'h0EC};
    vecs[1] = '{36'h2_03FFFFFF, 1'b0, 3'd2, 2'd3, 14'h3FFF, 10'h3FF};
    vecs[2] = '{36'h1_02000401, 1'b0, 3'd1, 2'd2, 14'h0001, 10'h001};
    vecs[3] = '{36'h4_FD000000, 1'b0, 3'd4, 2'd1, 14'h0000, 10'h000};
    vecs[4] = '{36'h5_01000BFF, 1'b1, 3'd5, 2'd1, 14'h0002, 10'h3FF};

    rst_n = 1'b0; app_af_addr = '0; app_af_wren = 1'b0; cmd_ready = 1'b0;
    step(); step();
    chk("rst_valid", cmd_valid, 0);
    chk("rst_afull", app_af_afull, 0);
    chk("rst_errs", {err_illegal, err_overflow}, 0);
    chk("rst_fields", {cmd_code, cmd_bank, cmd_row, cmd_col}, 0);
    chk("rst_cnts", {wr_cmd_cnt, rd_cmd_cnt}, 0);
    rst_n = 1'b1;
    step();

    // Single-command vectors: valid appears on the third edge counting the push edge.
    for (int i = 0; i < 5; i++) begin
      cmd_ready = vecs[i].ready_early;
      push(vecs[i].addr);
      chk("lat_e1", cmd_valid, 0);
      step();
      chk("lat_e2", cmd_valid, 0);
      step();
      chk("lat_e3", cmd_valid, 1);
      chk("vec_code", cmd_code, vecs[i].code);
      chk("vec_bank", cmd_bank, vecs[i].bank);
      chk("vec_row", cmd_row, vecs[i].row);
      chk("vec_col", cmd_col, vecs[i].col);
      cmd_ready = 1'b1;
      step();
      cmd_ready = 1'b0;
      count_model(vecs[i].code);
      chk("vec_drop", cmd_valid, 0);
      chk("vec_wr_cnt", wr_cmd_cnt, exp_wr[15:0]);
      chk("vec_rd_cnt", rd_cmd_cnt, exp_rd[15:0]);
    end

    // Held read stays stable while cmd_ready is low.
    push(36'h5_0083C154);
    wait_valid("hold_valid");
    for (int k = 0; k < 10; k++) begin
      chk("hold_valid_stable", cmd_valid, 1);
      chk("hold_fields", {cmd_code, cmd_bank, cmd_row, cmd_col}, {3'd5, 2'd0, 14'h20F0, 10'h154});
      chk("hold_rd_cnt", rd_cmd_cnt, exp_rd[15:0]);
      step();
    end
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    count_model(3'd5);
    chk("hold_release", cmd_valid, 0);
    chk("hold_rd_cnt_inc", rd_cmd_cnt, exp_rd[15:0]);

    // Illegal code followed by refresh.
    cmd_ready = 1'b1;
    app_af_addr = 36'h7_00000000; app_af_wren = 1'b1;
    step();
    app_af_addr = 36'h1_00000000;
    step();
    app_af_wren = 1'b0;
    nvalid = 0; seen_code = '0;
    for (int k = 0; k < 10; k++) begin
      if (cmd_valid) begin nvalid++; seen_code = cmd_code; end
      step();
    end
    cmd_ready = 1'b0;
    chk("ill_flag", err_illegal, 1);
    chk("ill_nvalid", nvalid, 1);
    chk("ill_refresh_code", seen_code, 3'd1);
    chk("ill_cnts", {wr_cmd_cnt, rd_cmd_cnt}, {exp_wr[15:0], exp_rd[15:0]});

    // 17 back-to-back pushes with the consumer stalled.
    for (int i = 1; i <= 17; i++) begin
      app_af_addr = {4'h4, 32'(i)};
      app_af_wren = 1'b1;
      step();
      chk("ovf_afull", app_af_afull, (i >= 12));
      chk("ovf_flag", err_overflow, (i == 17));
    end
    app_af_wren = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      wait_valid("drain_valid");
      chk("drain_order", {cmd_code, cmd_col}, {3'd4, 10'(k)});
      cmd_ready = 1'b1;
      step();
      cmd_ready = 1'b0;
      count_model(3'd4);
      chk("drain_bubble", cmd_valid, 0);
      if (k < 16) begin
        step();
        chk("drain_b2b", cmd_valid, 1);
      end
    end
    chk("drain_wr_cnt", wr_cmd_cnt, exp_wr[15:0]);
    repeat (4) step();
    chk("drain_no_17th", cmd_valid, 0);
    chk("drain_afull", app_af_afull, 0);

    // Asynchronous reset while holding with five entries queued behind.
    for (int i = 0; i < 6; i++) begin
      app_af_addr = 36'h5_03FFFFFF;
      app_af_wren = 1'b1;
      step();
    end
    app_af_wren = 1'b0;
    wait_valid("mid_valid");
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", cmd_valid, 0);
    chk("mid_rst_errs", {err_illegal, err_overflow, app_af_afull}, 0);
    chk("mid_rst_fields", {cmd_code, cmd_bank, cmd_row, cmd_col}, 0);
    chk("mid_rst_cnts", {wr_cmd_cnt, rd_cmd_cnt}, 0);
    exp_wr = 0; exp_rd = 0;
    @(negedge clk0);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("post_rst_quiet", cmd_valid, 0);
    end

    // Write counter wrap: three real writes, then preload near the top.
    do_write_cmd(32'h0000_0010);
    do_write_cmd(32'h0000_0020);
    do_write_cmd(32'h0000_0030);
    force dut.wr_cnt_q = 16'hFFFE;
    #1;
    release dut.wr_cnt_q;
    exp_wr = 16'hFFFE;
    step();
    chk("wrap_preload", wr_cmd_cnt, 16'hFFFE);
    do_write_cmd(32'h0000_0040);
    do_write_cmd(32'h0000_0050);
    chk("wrap_zero", wr_cmd_cnt, 16'h0000);
    do_write_cmd(32'h0000_0060);
    chk("wrap_rd_untouched", rd_cmd_cnt, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
